sec_bcd_counter: RTL and testbench
==================================

SEC_BCD_COUNTER -- requirements
Module: sec_bcd_counter

Interface
REQ-001 Parameter CLK_DIV, default 50000000, SHALL set the number of clk cycles per one-second tick; legal range is 2 or more.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  pause control; 1 = frozen, 0 = running.
REQ-005 m  input  1  count direction; 0 = up, 1 = down.
REQ-006 clr  input  1  synchronous clear to 00.
REQ-007 sec_ones  output  4  BCD seconds units digit, 0-9.
REQ-008 sec_tens  output  3  seconds tens digit, 0-5.
REQ-009 carry  output  1  one-cycle pulse on 59->00 (up) or 00->59 (down) wrap; the minutes stage consumes it as its count strobe.
REQ-010 tick  output  1  one-cycle pulse marking each internal one-second step.

Function
REQ-011 Internal prescaler SHALL count 0..CLK_DIV-1 while enable=0 and clr=0, wrapping to 0.
REQ-012 tick SHALL be registered and high for exactly the one cycle after the prescaler reaches CLK_DIV-1.
REQ-013 Tick period SHALL be exactly CLK_DIV cycles while running.
REQ-014 On each tick the 00-59 value SHALL step by one, in the direction given by m sampled on that same edge.
REQ-015 Up step: sec_ones 9->0 SHALL increment sec_tens; 59 SHALL go to 00.
REQ-016 Down step: sec_ones 0->9 SHALL decrement sec_tens; 00 SHALL go to 59.
REQ-017 carry SHALL assert in the same cycle the wrapped value (00 up, 59 down) first appears on the outputs, and SHALL deassert the next cycle.
REQ-018 carry SHALL never assert on a non-wrapping step, on clr, or on reset.
REQ-019 Outputs SHALL be registered; combinational paths from inputs to outputs are not allowed.
REQ-020 enable=1 SHALL hold the prescaler, digits and direction state, and force tick=0 and carry=0.
REQ-021 A pause SHALL preserve the partial prescaler count; counting resumes from that count when enable returns to 0.
REQ-022 clr=1 SHALL, on the next edge, set the digits to 00 and the prescaler to 0, and force tick=0 and carry=0.
REQ-023 clr SHALL take priority over tick, enable and m.
REQ-024 A change of m between ticks SHALL take effect only at the next tick; the prescaler is not disturbed.
REQ-025 Digits SHALL never leave the legal ranges; sec_ones 10-15 and sec_tens 6-7 are unreachable.
REQ-026 If an illegal state is reached anyway, the next tick SHALL load 00.

Reset
REQ-027 reset=1 SHALL immediately, without waiting for a clk edge, force sec_ones=0, sec_tens=0, the prescaler to 0, tick=0 and carry=0.
REQ-028 These values SHALL hold for as long as reset is high, regardless of clk, enable, m or clr.
REQ-029 Release of reset SHALL be synchronous to clk.
REQ-030 The first tick after release SHALL occur exactly CLK_DIV cycles later.
REQ-031 Reset asserted mid-count or mid-carry SHALL abort the count; no partial carry pulse is allowed.

Verification (CLK_DIV=4)
REQ-032 Reset, then m=0 and enable=0 for 240 cycles:
- tick fires every 4 cycles;
- value steps 00,01..59, then 00;
- carry is high exactly one cycle, coincident with 00.
REQ-033 Start from reset with m=1:
- first tick gives 59 with carry=1;
- next tick gives 58 with carry=0;
- the 50->49 step is checked.
REQ-034 Pause mid-period at 09 with the prescaler at 2, hold 10 cycles:
- outputs are frozen and tick=0;
- after release, the next tick arrives 2 cycles later and gives 10.
REQ-035 clr asserted in the same cycle the prescaler reaches 3 with the value at 59:
- result is 00 with carry=0;
- the next tick comes 4 cycles after clr deasserts.
REQ-036 Async reset pulse between clk edges at value 37:
- outputs go to 00 before the next edge;
- carry is never seen high;
- counting resumes correctly after release.
REQ-037 Toggle m at value 30 between ticks:
- the next tick gives 29;
- the tick period is unchanged at 4 cycles.

Source files
------------

// File: rtl/sec_bcd_counter.sv
// Seconds stage of a BCD clock: prescaled 1 s tick stepping a 00-59 up/down count.
// Latency: all outputs registered; a step appears on the edge the prescaler wraps.
// Backpressure: none; enable=1 freezes all state, clr=1 zeroes it synchronously.
module sec_bcd_counter #(
    parameter int CLK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       m,
    input  logic       clr,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic       carry,
    output logic       tick
);

    localparam int             PW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    ones_q, ones_d;
    logic [2:0]    tens_q, tens_d;
    logic          tick_q, tick_d;
    logic          carry_q, carry_d;

    logic          at_max;
    logic          illegal;

    assign at_max  = (presc_q == PRESC_MAX);
    assign illegal = (ones_q > 4'd9) || (tens_q > 3'd5);

    // Next state: clr beats everything, enable freezes, otherwise prescale and step.
    always_comb begin
        presc_d = presc_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        tick_d  = 1'b0;
        carry_d = 1'b0;
        if (clr) begin
            presc_d = '0;
            ones_d  = 4'd0;
            tens_d  = 3'd0;
        end else if (!enable) begin
            if (at_max) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (illegal) begin
                    // Recover from a corrupted digit pair by restarting at 00.
                    ones_d = 4'd0;
                    tens_d = 3'd0;
                end else if (!m) begin
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        if (tens_q == 3'd5) begin
                            tens_d  = 3'd0;
                            carry_d = 1'b1;
                        end else begin
                            tens_d = tens_q + 3'd1;
                        end
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end else begin
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        if (tens_q == 3'd0) begin
                            tens_d  = 3'd5;
                            carry_d = 1'b1;
                        end else begin
                            tens_d = tens_q - 3'd1;
                        end
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // State register; reset clears immediately so no partial carry can escape.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            ones_q  <= 4'd0;
            tens_q  <= 3'd0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            tick_q  <= tick_d;
            carry_q <= carry_d;
        end
    end

    assign sec_ones = ones_q;
    assign sec_tens = tens_q;
    assign carry    = carry_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_sec_bcd_counter.sv
// Randomised and directed bench for sec_bcd_counter with CLK_DIV=4.
// The reference keeps the time as an integer 0..59 and the prescaler as an integer.
// Outputs are sampled 1 time unit after each rising edge.
module tb_sec_bcd_counter;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       m;
    logic       clr;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic       carry;
    logic       tick;

    sec_bcd_counter #(.CLK_DIV(DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .m        (m),
        .clr      (clr),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .carry    (carry),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state
    int mdl_presc = 0;
    int mdl_sec   = 0;
    int mdl_tick  = 0;
    int mdl_carry = 0;
    int cyc       = 0;

    int watch_carry  = 0;
    int carry_glitch = 0;

    always @(posedge carry) if (watch_carry != 0) carry_glitch++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        if (obs !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int dut_sec();
        return int'(sec_tens) * 10 + int'(sec_ones);
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".ones"},  32'(sec_ones), mdl_sec % 10);
        check_val({tag, ".tens"},  32'(sec_tens), mdl_sec / 10);
        check_val({tag, ".tick"},  32'(tick),     mdl_tick);
        check_val({tag, ".carry"}, 32'(carry),    mdl_carry);
    endtask

    // Behaviour at a rising edge, from the inputs present at that edge.
    task automatic model_edge();
        mdl_tick  = 0;
        mdl_carry = 0;
        if (reset) begin
            mdl_presc = 0;
            mdl_sec   = 0;
        end else if (clr) begin
            mdl_presc = 0;
            mdl_sec   = 0;
        end else if (!enable) begin
            if (mdl_presc == DIV - 1) begin
                mdl_presc = 0;
                mdl_tick  = 1;
                if (!m) begin
                    mdl_carry = (mdl_sec == 59) ? 1 : 0;
                    mdl_sec   = (mdl_sec + 1) % 60;
                end else begin
                    mdl_carry = (mdl_sec == 0) ? 1 : 0;
                    mdl_sec   = (mdl_sec + 59) % 60;
                end
            end else begin
                mdl_presc = mdl_presc + 1;
            end
        end
    endtask

    // One clock: edge, model update, sample 1 unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_outputs(tag);
    endtask

    // Called between edges; outputs must clear without any clock.
    task automatic async_reset_on();
        reset     = 1'b1;
        mdl_presc = 0;
        mdl_sec   = 0;
        mdl_tick  = 0;
        mdl_carry = 0;
        #1;
        check_outputs("rst_async");
    endtask

    task automatic release_reset();
        step("rst_hold");
        step("rst_hold");
        #2;
        reset = 1'b0;
    endtask

    task automatic fresh_reset();
        #1;
        async_reset_on();
        release_reset();
    endtask

    int ticks;
    int carries;
    int n;
    int found;

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        m      = 1'b0;
        clr    = 1'b0;
        #3;
        check_outputs("rst_init");
        // Reset dominates whatever else is driven.
        enable = 1'b1; m = 1'b1; clr = 1'b1;
        step("rst_hold_in");
        enable = 1'b0; m = 1'b0; clr = 1'b0;
        step("rst_hold_in");
        #2;
        reset = 1'b0;

        // Full up-count lap.
        ticks = 0; carries = 0;
        for (int i = 0; i < 240; i++) begin
            step("up");
            if (tick === 1'b1) ticks++;
            if (carry === 1'b1) begin
                carries++;
                check_val("up_carry_at_00", 32'(dut_sec()), 0);
            end
            if (i == 3) check_val("up_first_tick", 32'(tick), 1);
        end
        check_val("up_ticks", 32'(ticks), 60);
        check_val("up_carries", 32'(carries), 1);
        check_val("up_final", 32'(dut_sec()), 0);

        // Down count from reset.
        fresh_reset();
        m = 1'b1;
        repeat (4) step("dn");
        check_val("dn_first_val", 32'(dut_sec()), 59);
        check_val("dn_first_carry", 32'(carry), 1);
        repeat (4) step("dn");
        check_val("dn_second_val", 32'(dut_sec()), 58);
        check_val("dn_second_carry", 32'(carry), 0);
        repeat (32) step("dn");
        check_val("dn_50", 32'(dut_sec()), 50);
        repeat (4) step("dn");
        check_val("dn_49_ones", 32'(sec_ones), 9);
        check_val("dn_49_tens", 32'(sec_tens), 4);
        check_val("dn_49_carry", 32'(carry), 0);

        // Reset while carry is high.
        fresh_reset();
        m = 1'b1;
        repeat (4) step("midcarry");
        check_val("midcarry_seen", 32'(carry), 1);
        #1;
        async_reset_on();
        check_val("midcarry_dropped", 32'(carry), 0);
        release_reset();

        // Pause at 09 with the prescaler at 2.
        m = 1'b0;
        for (int i = 0; i < 200 && !(mdl_sec == 9 && mdl_presc == 2); i++) step("to09");
        check_val("pause_reached", 32'(dut_sec()), 9);
        enable = 1'b1;
        for (int i = 0; i < 10; i++) step("pause");
        check_val("pause_frozen", 32'(dut_sec()), 9);
        enable = 1'b0;
        step("resume");
        check_val("resume_no_tick", 32'(tick), 0);
        step("resume");
        check_val("resume_tick", 32'(tick), 1);
        check_val("resume_val", 32'(dut_sec()), 10);

        // clr at 59 just as the prescaler reaches 3.
        fresh_reset();
        m = 1'b1;
        repeat (4) step("to59");
        repeat (3) step("to59");
        clr = 1'b1;
        step("clr");
        clr = 1'b0;
        check_val("clr_val", 32'(dut_sec()), 0);
        check_val("clr_carry", 32'(carry), 0);
        check_val("clr_tick", 32'(tick), 0);
        found = 0;
        for (int i = 1; i <= 10 && found == 0; i++) begin
            step("after_clr");
            if (tick === 1'b1) found = i;
        end
        check_val("clr_next_tick", 32'(found), 4);

        // Async reset between edges at 37.
        fresh_reset();
        m = 1'b0;
        for (int i = 0; i < 400 && mdl_sec != 37; i++) step("to37");
        step("at37");
        check_val("at37", 32'(dut_sec()), 37);
        watch_carry = 1;
        #2;
        async_reset_on();
        release_reset();
        repeat (8) step("after37");
        watch_carry = 0;
        check_val("rst37_no_carry", 32'(carry_glitch), 0);
        check_val("rst37_resume", 32'(dut_sec()), 2);

        // Direction change between ticks at 30.
        fresh_reset();
        m = 1'b0;
        for (int i = 0; i < 400 && !(mdl_sec == 30 && mdl_presc == 1); i++) step("to30");
        check_val("at30", 32'(dut_sec()), 30);
        m = 1'b1;
        found = 0;
        for (int i = 1; i <= 10 && found == 0; i++) begin
            step("mtoggle");
            if (tick === 1'b1) found = i;
        end
        check_val("mtoggle_period", 32'(found + 1), 4);
        check_val("mtoggle_val", 32'(dut_sec()), 29);

        // Random traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) m = ~m;
            clr = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 399) == 0) fresh_reset();
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
